// File: rtl/cam_capture.sv
// DVP sensor capture: synchronises the sensor bus, assembles RGB565/RAW8 bytes into widened pixels with x/y tags.
// Latency: pix_valid_o 4 sys_clk_i cycles after pclk is first sampled high; no backpressure, pixels stream at sensor rate.
module cam_capture #(
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 8,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int SKIP_FRAMES = 10,
  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1,
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic              pclk_i,
  input  logic [DATA_W-1:0] cam_data_i,
  input  logic              mode_i,
  output logic [OUT_W-1:0]  cam_red_o,
  output logic [OUT_W-1:0]  cam_green_o,
  output logic [OUT_W-1:0]  cam_blue_o,
  output logic              pix_valid_o,
  output logic [XW-1:0]     pix_x_o,
  output logic [YW-1:0]     pix_y_o,
  output logic              frame_start_o,
  output logic              cam_done_o,
  output logic              frame_err_o
);
  localparam int XCW = XW + 1;
  localparam int YCW = YW + 1;
  localparam int SW  = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  typedef enum logic [1:0] {ST_SKIP, ST_WAIT, ST_CAPT} state_t;
  localparam state_t RST_ST = (SKIP_FRAMES == 0) ? ST_WAIT : ST_SKIP;

  logic [DATA_W+2:0] r_s1, r_s2;
  logic [2:0]        r_s3;
  logic              w_pclk, w_href, w_vs;
  logic              r_a_cap, r_a_href, r_a_hrise, r_a_hfall, r_a_vrise, r_a_vfall;
  logic [7:0]        r_a_dat;
  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_skip_cnt;
  logic              r_mode, r_phase, r_done, r_errflag;
  logic [7:0]        r_first;
  logic [XCW-1:0]    r_x;
  logic [YCW-1:0]    r_y;
  logic              w_frame_go, w_in_capt, w_phase_eff, w_byte, w_emit, w_inb, w_last, w_err;
  logic              r_b_vld, r_b_last, r_b_fs, r_b_err, r_b_gray_md, r_c_last;
  logic [4:0]        r_b_r, r_b_b;
  logic [5:0]        r_b_g;
  logic [7:0]        r_b_gray;
  logic [XW-1:0]     r_b_x;
  logic [YW-1:0]     r_b_y;
  logic [OUT_W-1:0]  w_r_x, w_g_x, w_b_x, w_y_x;

  assign w_pclk = r_s2[DATA_W+2];
  assign w_href = r_s2[DATA_W+1];
  assign w_vs   = r_s2[DATA_W];

  // Edges compare stage 2 against the extra register; data comes from stage 2 too.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_a_cap   <= 1'b0;
      r_a_href  <= 1'b0;
      r_a_hrise <= 1'b0;
      r_a_hfall <= 1'b0;
      r_a_vrise <= 1'b0;
      r_a_vfall <= 1'b0;
      r_a_dat   <= '0;
    end else begin
      r_s1      <= {pclk_i, href_i, vsync_i, cam_data_i};
      r_s2      <= r_s1;
      r_s3      <= r_s2[DATA_W+2:DATA_W];
      r_a_cap   <= w_pclk & ~r_s3[2];
      r_a_href  <= w_href;
      r_a_hrise <= w_href & ~r_s3[1];
      r_a_hfall <= ~w_href & r_s3[1];
      r_a_vrise <= w_vs & ~r_s3[0];
      r_a_vfall <= ~w_vs & r_s3[0];
      r_a_dat   <= r_s2[7:0];
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state    <= RST_ST;
      r_skip_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_SKIP && r_a_vfall) r_skip_cnt <= r_skip_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_go  = 1'b0;
    unique case (r_state)
      ST_SKIP: if (r_a_vfall && r_skip_cnt == SW'(SKIP_FRAMES - 1)) w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_a_vfall) begin
        w_state_nxt = ST_CAPT;
        w_frame_go  = 1'b1;
      end
      ST_CAPT: if (r_a_vrise) w_state_nxt = ST_WAIT;
      default: w_state_nxt = RST_ST;
    endcase
    w_in_capt   = (r_state == ST_CAPT);
    w_phase_eff = r_a_hrise ? 1'b0 : r_phase;
    w_byte      = w_in_capt && r_a_cap && r_a_href;
    w_emit      = w_byte && (r_mode || w_phase_eff);
    w_inb       = (r_x < XCW'(H_ACT)) && (r_y < YCW'(V_ACT));
    w_last      = w_emit && w_inb && !r_errflag && !r_done &&
                  (r_x == XCW'(H_ACT - 1)) && (r_y == YCW'(V_ACT - 1));
    // Once a frame has completed, later line/frame anomalies are not reported against it.
    w_err       = w_in_capt && !r_done &&
                  ((r_a_hfall && ((r_x != XCW'(H_ACT)) || (!r_mode && r_phase))) || r_a_vrise);
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_mode      <= 1'b0;
      r_phase     <= 1'b0;
      r_done      <= 1'b0;
      r_errflag   <= 1'b0;
      r_first     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_b_vld     <= 1'b0;
      r_b_last    <= 1'b0;
      r_b_fs      <= 1'b0;
      r_b_err     <= 1'b0;
      r_b_gray_md <= 1'b0;
      r_b_r       <= '0;
      r_b_g       <= '0;
      r_b_b       <= '0;
      r_b_gray    <= '0;
      r_b_x       <= '0;
      r_b_y       <= '0;
    end else begin
      r_b_vld  <= w_emit && w_inb;
      r_b_last <= w_last;
      r_b_fs   <= w_frame_go;
      r_b_err  <= w_err;
      if (w_frame_go) begin
        r_mode    <= mode_i;
        r_x       <= '0;
        r_y       <= '0;
        r_phase   <= 1'b0;
        r_done    <= 1'b0;
        r_errflag <= 1'b0;
      end else if (w_in_capt) begin
        if (r_a_hfall) begin
          r_x     <= '0;
          r_y     <= (&r_y) ? r_y : r_y + 1'b1;
          r_phase <= 1'b0;
        end else if (w_byte) begin
          if (w_emit) begin
            r_x     <= (&r_x) ? r_x : r_x + 1'b1;
            r_phase <= 1'b0;
          end else begin
            r_phase <= 1'b1;
            r_first <= r_a_dat;
          end
        end else if (r_a_hrise) begin
          r_phase <= 1'b0;
        end
        if (w_last) r_done <= 1'b1;
        if (w_err) r_errflag <= 1'b1;
      end
      if (w_emit && w_inb) begin
        r_b_gray_md <= r_mode;
        r_b_r       <= r_first[7:3];
        r_b_g       <= {r_first[2:0], r_a_dat[7:5]};
        r_b_b       <= r_a_dat[4:0];
        r_b_gray    <= r_a_dat;
        r_b_x       <= r_x[XW-1:0];
        r_b_y       <= r_y[YW-1:0];
      end
    end
  end

  // Left-align each channel and refill the low bits with its own MSBs (truncates when narrower).
  for (genvar k = 0; k < OUT_W; k++) begin : g_expand
    assign w_r_x[OUT_W-1-k] = r_b_r[4 - (k % 5)];
    assign w_g_x[OUT_W-1-k] = r_b_g[5 - (k % 6)];
    assign w_b_x[OUT_W-1-k] = r_b_b[4 - (k % 5)];
    assign w_y_x[OUT_W-1-k] = r_b_gray[7 - (k % 8)];
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      pix_valid_o   <= 1'b0;
      frame_start_o <= 1'b0;
      frame_err_o   <= 1'b0;
      cam_done_o    <= 1'b0;
      r_c_last      <= 1'b0;
      cam_red_o     <= '0;
      cam_green_o   <= '0;
      cam_blue_o    <= '0;
      pix_x_o       <= '0;
      pix_y_o       <= '0;
    end else begin
      pix_valid_o   <= r_b_vld;
      frame_start_o <= r_b_fs;
      frame_err_o   <= r_b_err;
      r_c_last      <= r_b_last;
      cam_done_o    <= r_c_last;
      if (r_b_vld) begin
        cam_red_o   <= r_b_gray_md ? w_y_x : w_r_x;
        cam_green_o <= r_b_gray_md ? w_y_x : w_g_x;
        cam_blue_o  <= r_b_gray_md ? w_y_x : w_b_x;
        pix_x_o     <= r_b_x;
        pix_y_o     <= r_b_y;
      end
    end
  end
endmodule
